// File: rtl/cache_assoc.sv
// ---------------------------------------------------------------------------
// cache_assoc
//
// Set-associative, write-back, write-allocate cache with 4-word blocks.
// A small FSM sits between the processor and the memory:
// it serves hits in zero stall cycles and handles misses by writing back a
// dirty victim and then filling the block.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | serve hits; on a miss pick a victim and leave
// WRITEBACK | push the dirty victim block to memory, wait for mem_ready
// ALLOCATE  | fetch the requested block, wait for mem_ready, install line
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset
//   proc_read    processor read request
//   proc_write   processor write request (wins over proc_read)
//   proc_addr    30-bit word address {tag, index, word[1:0]}
//   proc_wdata   write data
//   proc_rdata   read data, valid when proc_read=1 and proc_stall=0
//   proc_stall   processor must hold its request while high
//   mem_read     block fill request
//   mem_write    block write-back request
//   mem_addr     28-bit block address
//   mem_wdata    write-back block, word 0 in [31:0]
//   mem_rdata    fill block, valid in the mem_ready cycle
//   mem_ready    one-cycle completion pulse for the current memory request
// ---------------------------------------------------------------------------
module cache_assoc #(
    parameter int WAYS = 2,
    parameter int SETS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    localparam int IW = $clog2(SETS);
    localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TW = 28 - IW;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [AW-1:0] victim_q, victim_d;

    logic [WAYS-1:0] valid_q [SETS];
    logic [WAYS-1:0] dirty_q [SETS];
    logic [TW-1:0]   tag_q   [WAYS][SETS];
    logic [127:0]    data_q  [WAYS][SETS];
    logic [AW-1:0]   age_q   [WAYS][SETS];

    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic [1:0]    word;
    logic          req;

    logic          hit;
    logic [AW-1:0] hit_way;
    logic [AW-1:0] victim;
    logic          victim_found;
    logic [31:0]   hit_word;

    logic          wr_en;
    logic          fill_en;
    logic          age_en;
    logic [AW-1:0] age_way;
    logic [AW-1:0] age_ref;

    assign word = proc_addr[1:0];
    assign idx  = proc_addr[2 +: IW];
    assign tag  = proc_addr[29 -: TW];
    assign req  = proc_read | proc_write;

    // Tag lookup across all ways of the indexed set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[idx][w] && (tag_q[w][idx] == tag)) begin
                hit     = 1'b1;
                hit_way = AW'(w);
            end
        end
    end

    assign hit_word = data_q[hit_way][idx][{word, 5'b0} +: 32];

    // Victim: lowest invalid way, else the way whose age is the maximum.
    always_comb begin
        victim       = '0;
        victim_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found && !valid_q[idx][w]) begin
                victim       = AW'(w);
                victim_found = 1'b1;
            end
        end
        if (!victim_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[w][idx] == AW'(WAYS - 1)) begin
                    victim = AW'(w);
                end
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        victim_d   = victim_q;
        proc_stall = 1'b0;
        proc_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        wr_en      = 1'b0;
        fill_en    = 1'b0;
        age_en     = 1'b0;
        age_way    = hit_way;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        age_en = 1'b1;
                        if (proc_write) begin
                            wr_en = 1'b1;
                        end else begin
                            proc_rdata = hit_word;
                        end
                    end else begin
                        proc_stall = 1'b1;
                        victim_d   = victim;
                        if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
                            state_d = WRITEBACK;
                        end else begin
                            state_d = ALLOCATE;
                        end
                    end
                end
            end

            WRITEBACK: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {tag_q[victim_q][idx], idx};
                mem_wdata  = data_q[victim_q][idx];
                if (mem_ready) begin
                    state_d = ALLOCATE;
                end
            end

            ALLOCATE: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = proc_addr[29:2];
                if (mem_ready) begin
                    fill_en = 1'b1;
                    age_en  = 1'b1;
                    age_way = victim_q;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else if (fill_en) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
        end else if (wr_en) begin
            dirty_q[idx][hit_way] <= 1'b1;
        end
    end

    // Tag and data arrays need no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (fill_en) begin
                tag_q[victim_q][idx]  <= tag;
                data_q[victim_q][idx] <= mem_rdata;
            end else if (wr_en) begin
                data_q[hit_way][idx][{word, 5'b0} +: 32] <= proc_wdata;
            end
        end
    end

    // An invalid line being filled is treated as older than every valid
    // line, so all valid ways age by one when it comes in.
    assign age_ref = valid_q[idx][age_way] ? age_q[age_way][idx] : AW'(WAYS - 1);

    if (WAYS > 1) begin : g_lru
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int w = 0; w < WAYS; w++) begin
                    for (int s = 0; s < SETS; s++) begin
                        age_q[w][s] <= '0;
                    end
                end
            end else if (age_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (AW'(w) == age_way) begin
                        age_q[w][idx] <= '0;
                    end else if (valid_q[idx][w] && (age_q[w][idx] < age_ref)) begin
                        age_q[w][idx] <= age_q[w][idx] + AW'(1);
                    end
                end
            end
        end
    end else begin : g_no_lru
        for (genvar w = 0; w < WAYS; w++) begin : g_w
            for (genvar s = 0; s < SETS; s++) begin : g_s
                assign age_q[w][s] = '0;
            end
        end
    end

endmodule

// File: tb/tb_cache_assoc.sv
// ---------------------------------------------------------------------------
// tb_cache_assoc
//
// Directed bench for cache_assoc (WAYS=2, SETS=4). A memory responder
// answers every mem_read/mem_write with mem_ready in the third cycle the
// request is held. Fill data for block b, word k is {4'hA, b[23:0], k[3:0]}.
// ---------------------------------------------------------------------------
module tb_cache_assoc;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         proc_read = 1'b0;
    logic         proc_write = 1'b0;
    logic [29:0]  proc_addr = '0;
    logic [31:0]  proc_wdata = '0;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    int           resp_cnt = 0;
    int           rd_cnt = 0;
    int           wb_cnt = 0;
    logic [27:0]  last_rd_addr = '0;
    logic [27:0]  wb_addr = '0;
    logic [127:0] wb_data = '0;
    logic         spur = 1'b0;

    int          cyc;
    logic [31:0] rd;

    cache_assoc #(.WAYS(2), .SETS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] fill_blk(input logic [27:0] b);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) begin
            r[k*32 +: 32] = {4'hA, b[23:0], 4'(k)};
        end
        return r;
    endfunction

    always @(negedge clk) begin
        mem_ready = 1'b0;
        if (!rst_n || !(mem_read || mem_write)) begin
            resp_cnt = 0;
        end else if (resp_cnt == 2) begin
            mem_ready = 1'b1;
            resp_cnt  = 0;
            if (mem_write) begin
                wb_cnt++;
                wb_addr = mem_addr;
                wb_data = mem_wdata;
            end else begin
                rd_cnt++;
                last_rd_addr = mem_addr;
                mem_rdata    = fill_blk(mem_addr);
            end
        end else begin
            resp_cnt++;
        end
        if (spur) mem_ready = 1'b1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one request, holds it while stalled, returns the number of
    // cycles up to and including the hit cycle and the read data seen there.
    task automatic access(input logic wr, input logic rdq, input logic [29:0] a,
                          input logic [31:0] wd, output int n, output logic [31:0] data);
        logic done;
        proc_write = wr;
        proc_read  = rdq;
        proc_addr  = a;
        proc_wdata = wd;
        n    = 0;
        done = 1'b0;
        data = '0;
        while (!done && n < 50) begin
            #1;
            n++;
            if (!proc_stall) begin
                done = 1'b1;
                data = proc_rdata;
            end else begin
                @(posedge clk);
                #2;
            end
        end
        if (!done) check("access_timeout", 128'(n), 128'(0));
        @(posedge clk);
        #2;
        proc_read  = 1'b0;
        proc_write = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        #1;
        check("rst_stall", 128'(proc_stall), 128'(0));
        check("rst_mem_read", 128'(mem_read), 128'(0));
        check("rst_mem_write", 128'(mem_write), 128'(0));
        check("rst_mem_addr", 128'(mem_addr), 128'(0));
        check("rst_mem_wdata", mem_wdata, 128'(0));
        check("rst_rdata", 128'(proc_rdata), 128'(0));
        @(posedge clk); #2;

        // Cold read miss
        access(1'b0, 1'b1, 30'h10, 32'h0, cyc, rd);
        check("cold_cycles", 128'(cyc), 128'(5));
        check("cold_rdata", 128'(rd), 128'h0000_0000_0000_0000_0000_0000_A000_0040);
        check("cold_fill_addr", 128'(last_rd_addr), 128'h4);
        check("cold_rd_cnt", 128'(rd_cnt), 128'(1));

        // Write hit, then read hit of the written and a neighbour word
        access(1'b1, 1'b0, 30'h11, 32'hDEAD_BEEF, cyc, rd);
        check("wr_hit_cycles", 128'(cyc), 128'(1));
        access(1'b0, 1'b1, 30'h11, 32'h0, cyc, rd);
        check("rd_after_wr_cycles", 128'(cyc), 128'(1));
        check("rd_after_wr_data", 128'(rd), 128'hDEAD_BEEF);
        access(1'b0, 1'b1, 30'h12, 32'h0, cyc, rd);
        check("rd_word2_data", 128'(rd), 128'hA000_0042);
        check("no_mem_on_hits", 128'(rd_cnt), 128'(1));

        // Spurious mem_ready in IDLE is ignored
        spur = 1'b1;
        #1;
        check("spur_stall", 128'(proc_stall), 128'(0));
        @(posedge clk); #2;
        spur = 1'b0;
        @(posedge clk); #2;
        access(1'b0, 1'b1, 30'h10, 32'h0, cyc, rd);
        check("spur_hit_cycles", 128'(cyc), 128'(1));
        check("spur_hit_data", 128'(rd), 128'hA000_0040);

        // Read and write together: handled as a write, no read data
        access(1'b1, 1'b1, 30'h13, 32'h1234_5678, cyc, rd);
        check("both_cycles", 128'(cyc), 128'(1));
        check("both_rdata_zero", 128'(rd), 128'(0));
        access(1'b0, 1'b1, 30'h13, 32'h0, cyc, rd);
        check("both_readback", 128'(rd), 128'h1234_5678);

        // Fill way 1 of set 0, then evict the dirty LRU line (block 0x4)
        access(1'b0, 1'b1, 30'h20, 32'h0, cyc, rd);
        check("fill20_cycles", 128'(cyc), 128'(5));
        access(1'b0, 1'b1, 30'h40, 32'h0, cyc, rd);
        check("dirty_evict_cycles", 128'(cyc), 128'(8));
        check("dirty_evict_wb_cnt", 128'(wb_cnt), 128'(1));
        check("dirty_evict_wb_addr", 128'(wb_addr), 128'h4);
        check("dirty_evict_wb_data", wb_data, 128'h1234_5678_A000_0042_DEAD_BEEF_A000_0040);
        check("dirty_evict_rdata", 128'(rd), 128'hA000_0100);

        // Clean LRU eviction
        do_reset();
        access(1'b0, 1'b1, 30'h00, 32'h0, cyc, rd);
        check("lru_fill00", 128'(cyc), 128'(5));
        access(1'b0, 1'b1, 30'h20, 32'h0, cyc, rd);
        check("lru_fill20", 128'(cyc), 128'(5));
        access(1'b0, 1'b1, 30'h00, 32'h0, cyc, rd);
        check("lru_hit00_cycles", 128'(cyc), 128'(1));
        check("lru_hit00_data", 128'(rd), 128'hA000_0000);
        access(1'b0, 1'b1, 30'h40, 32'h0, cyc, rd);
        check("lru_miss40_cycles", 128'(cyc), 128'(5));
        check("lru_miss40_data", 128'(rd), 128'hA000_0100);
        check("lru_clean_no_wb", 128'(wb_cnt), 128'(1));
        access(1'b0, 1'b1, 30'h00, 32'h0, cyc, rd);
        check("lru_rehit00", 128'(cyc), 128'(1));
        access(1'b0, 1'b1, 30'h20, 32'h0, cyc, rd);
        check("lru_20_evicted", 128'(cyc), 128'(5));

        // Dirty LRU victim from a write miss
        do_reset();
        access(1'b1, 1'b0, 30'h00, 32'hCAFE_F00D, cyc, rd);
        check("wmiss_cycles", 128'(cyc), 128'(5));
        access(1'b0, 1'b1, 30'h20, 32'h0, cyc, rd);
        check("wmiss_fill20", 128'(cyc), 128'(5));
        access(1'b0, 1'b1, 30'h40, 32'h0, cyc, rd);
        check("wb_cycles", 128'(cyc), 128'(8));
        check("wb_cnt", 128'(wb_cnt), 128'(2));
        check("wb_addr", 128'(wb_addr), 128'h0);
        check("wb_data", wb_data, 128'hA000_0003_A000_0002_A000_0001_CAFE_F00D);
        check("wb_then_fill_addr", 128'(last_rd_addr), 128'h10);
        check("wb_rdata", 128'(rd), 128'hA000_0100);

        // Reset in the middle of ALLOCATE
        do_reset();
        access(1'b0, 1'b1, 30'h10, 32'h0, cyc, rd);
        check("pre_rst_fill", 128'(cyc), 128'(5));
        proc_read = 1'b1;
        proc_addr = 30'h50;
        #1;
        check("midrst_req_stall", 128'(proc_stall), 128'(1));
        @(posedge clk); #2;
        check("midrst_alloc_read", 128'(mem_read), 128'(1));
        check("midrst_alloc_addr", 128'(mem_addr), 128'h14);
        rst_n     = 1'b0;
        proc_read = 1'b0;
        @(posedge clk); #2;
        check("midrst_mem_read", 128'(mem_read), 128'(0));
        check("midrst_stall", 128'(proc_stall), 128'(0));
        check("midrst_mem_addr", 128'(mem_addr), 128'(0));
        rst_n = 1'b1;
        access(1'b0, 1'b1, 30'h10, 32'h0, cyc, rd);
        check("post_rst_miss", 128'(cyc), 128'(5));
        check("post_rst_data", 128'(rd), 128'hA000_0040);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cache_assoc.md
CACHE_ASSOC -- requirements
Module: cache_assoc

Interface
REQ-001 Parameter WAYS, default 2: associativity; legal values 1, 2, 4, 8.
REQ-002 Parameter SETS, default 4: sets per way; power of two, 2..64.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 proc_read  input  1  processor read request.
REQ-006 proc_write  input  1  processor write request; takes precedence when both requests are high.
REQ-007 proc_addr  input  30  word address: [1:0] word-in-block, next log2(SETS) bits index, remainder tag.
REQ-008 proc_wdata  input  32  write data.
REQ-009 proc_rdata  output  32  read data; valid when proc_read=1 and proc_stall=0.
REQ-010 proc_stall  output  1  processor must hold request and operands while high.
REQ-011 mem_read  output  1  block fill request.
REQ-012 mem_write  output  1  block write-back request.
REQ-013 mem_addr  output  28  block address, equal to address bits [31:4].
REQ-014 mem_wdata  output  128  write-back block; word 0 in [31:0].
REQ-015 mem_rdata  input  128  fill block; valid in the mem_ready cycle.
REQ-016 mem_ready  input  1  one-cycle completion pulse for the current mem_read or mem_write.

Function
REQ-017 The cache SHALL be WAYS-way set-associative, write-back, write-allocate, with 4-word blocks and per-line valid, dirty and tag bits.
REQ-018 The FSM SHALL have states IDLE, WRITEBACK and ALLOCATE.
REQ-019 In IDLE, a request with a tag match in a valid way of the indexed set SHALL be a hit: proc_stall=0 in the same cycle.
REQ-020 On a read hit, proc_rdata SHALL be combinational from the matching way and word; with no read hit, proc_rdata=0.
REQ-021 On a write hit, the addressed word SHALL be updated and dirty set at the next edge, with zero stall cycles.
REQ-022 On a miss, proc_stall SHALL be 1 combinationally in the request cycle and SHALL remain 1 until the hit cycle after the fill.
REQ-023 Victim selection SHALL be the lowest-index invalid way; if every way is valid, the least-recently-used way.
REQ-024 LRU SHALL be true LRU via per-line log2(WAYS)-bit age counters: the accessed way becomes 0, ways younger than it increment, and the rest hold; updates occur on every hit and every fill.
REQ-025 On a miss, a dirty victim SHALL take IDLE->WRITEBACK; a clean victim SHALL take IDLE->ALLOCATE.
REQ-026 In WRITEBACK, mem_write=1, mem_addr={victim tag, index} and mem_wdata=victim block SHALL be held steady until mem_ready; then the FSM SHALL move to ALLOCATE.
REQ-027 In ALLOCATE, mem_read=1 and mem_addr=proc_addr[29:2] SHALL be held until mem_ready; then the block, tag and valid=1 SHALL be written, dirty cleared, and the FSM SHALL return to IDLE.
REQ-028 The request then re-evaluates as a hit, so miss latency is memory latency plus 1 cycle, and a write miss merges its word and sets dirty on that hit.
REQ-029 mem_read and mem_write SHALL never both be 1.
REQ-030 With no request in IDLE, proc_stall SHALL be 0 and no state SHALL change.
REQ-031 With WAYS=1, behaviour SHALL reduce to direct-mapped with no LRU storage.
REQ-032 A mem_ready received in IDLE SHALL be ignored.

Reset
REQ-033 rst_n=0 at an edge SHALL clear all valid, dirty and age bits, force IDLE, and drive mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, proc_stall=0 from the next cycle; tag and data contents are don't-care.
REQ-034 Reset during WRITEBACK or ALLOCATE SHALL abandon the transaction, with no line update and no pending request after release.

Verification (WAYS=2, SETS=4; mem_ready 3 cycles after request)
REQ-035 Cold read proc_addr=0x10 -> stall, ALLOCATE with mem_addr=0x4, fill, then proc_rdata=word 0 of fill, stall low in the 5th cycle.
REQ-036 Write 0xDEADBEEF to 0x11 after REQ-035 -> no stall; a later read of 0x11 returns 0xDEADBEEF with no memory access.
REQ-037 Fill 0x00 and 0x20 (set 0, ways 0/1), read 0x00, then read 0x40 -> way 1 (0x20) evicted, clean so no mem_write; re-reading 0x00 still hits.
REQ-038 Dirty 0x00 plus 0x20 resident, LRU=0x00, read 0x40 -> mem_write with mem_addr=0x0 and mem_wdata carrying the written word, then mem_read with mem_addr=0x10.
REQ-039 rst_n=0 for one cycle mid-ALLOCATE -> mem_read=0 next cycle, and a re-read of the prior hit address misses.
REQ-040 proc_read and proc_write both high to a hit address -> treated as a write, and dirty is set.
